ov7670_frame_fifo: RTL and testbench

- Single-clock pixel FIFO between the OV7670 capture stage (newPixel / pixelData, 16-bit RGB565) and the ILI9341 display driver.
- Removes the direct wire between the two stages: capture writes pixels at camera rate, and the display pulls them at its own rate.
- Frame-aligned: a frame-start pulse flushes stale data.
- Provides the display with a per-pixel frame index and overflow/underflow diagnostics.

---
 rtl/ov7670_frame_fifo.sv | 181 ++++++++++++++++++
 tb/tb_ov7670_frame_fifo.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ov7670_frame_fifo.sv
// Frame-aligned pixel FIFO between the OV7670 capture stage and the ILI9341 display driver.
// Capture pushes at camera rate, display pops at its own rate, and frameStart flushes stale data.
module ov7670_frame_fifo #(
    parameter int DATA_WIDTH   = 16,
    parameter int DEPTH        = 512,
    parameter int FRAME_PIXELS = 76800
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frameStart,
    input  logic                     newPixel,
    input  logic [DATA_WIDTH-1:0]    pixelDataIn,
    input  logic                     pixelReq,
    output logic [DATA_WIDTH-1:0]    pixelDataOut,
    output logic                     pixelValid,
    output logic [16:0]              pixelAddr,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full,
    output logic                     frameDone,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L    = (AW+1)'(DEPTH);
    localparam logic [16:0] FRAME_LEN  = 17'(FRAME_PIXELS);
    localparam logic [16:0] FRAME_LAST = 17'(FRAME_PIXELS - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DRAIN = 2'd2} state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_addr_s;
    logic [AW:0]            level_q, level_d;
    logic [16:0]            write_count_q, write_count_d, read_count_q, read_count_d;
    logic [16:0]            pixel_addr_q, pixel_addr_d;
    logic [DATA_WIDTH-1:0]  pixel_data_q, pixel_data_d;
    logic                   pixel_valid_q, pixel_valid_d, frame_done_q, frame_done_d;
    logic                   overflow_q, overflow_d, underflow_q, underflow_d;
    logic                   empty_q, empty_d, full_q, full_d;
    logic                   wr_en_s, rd_en_s, active_s;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    // Next-state logic: flush, write acceptance, pop and frame bookkeeping.
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        wr_addr_s     = wr_ptr_q;
        write_count_d = write_count_q;
        read_count_d  = read_count_q;
        pixel_addr_d  = pixel_addr_q;
        pixel_data_d  = pixel_data_q;
        pixel_valid_d = 1'b0;
        frame_done_d  = 1'b0;
        overflow_d    = overflow_q;
        underflow_d   = underflow_q;
        wr_en_s       = 1'b0;
        rd_en_s       = 1'b0;
        active_s      = (state_q == STREAM) || (state_q == DRAIN);
        level_d       = level_q;

        if (frameStart) begin
            // A coincident write lands as pixel 0 of the new frame; a coincident pop is dropped.
            rd_ptr_d    = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            read_count_d = 17'd0;
            state_d     = STREAM;
            if (newPixel) begin
                wr_en_s       = 1'b1;
                wr_addr_s     = '0;
                wr_ptr_d      = AW'(1);
                level_d       = (AW+1)'(1);
                write_count_d = 17'd1;
                state_d       = (FRAME_LEN == 17'd1) ? DRAIN : STREAM;
            end else begin
                wr_ptr_d      = '0;
                level_d       = '0;
                write_count_d = 17'd0;
            end
        end else begin
            rd_en_s = pixelReq && !empty_q && active_s;
            if (pixelReq && empty_q && active_s) begin
                underflow_d = 1'b1;
            end else begin
                underflow_d = underflow_q;
            end

            if (newPixel && (state_q == STREAM)) begin
                // Dropped writes still count so the frame length stays aligned.
                write_count_d = write_count_q + 17'd1;
                if (write_count_d == FRAME_LEN) begin
                    state_d = DRAIN;
                end else begin
                    state_d = STREAM;
                end
                if (!full_q || rd_en_s) begin
                    wr_en_s  = 1'b1;
                    wr_ptr_d = wr_ptr_q + AW'(1);
                end else begin
                    overflow_d = 1'b1;
                end
            end else begin
                write_count_d = write_count_q;
            end

            if (rd_en_s) begin
                rd_ptr_d      = rd_ptr_q + AW'(1);
                pixel_valid_d = 1'b1;
                pixel_addr_d  = read_count_q;
                pixel_data_d  = mem[rd_ptr_q];
                read_count_d  = read_count_q + 17'd1;
                if (read_count_q == FRAME_LAST) begin
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    frame_done_d = 1'b0;
                end
            end else begin
                pixel_valid_d = 1'b0;
            end

            level_d = level_q + {{AW{1'b0}}, wr_en_s} - {{AW{1'b0}}, rd_en_s};
        end

        empty_d = (level_d == '0);
        full_d  = (level_d == DEPTH_L);
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            write_count_q <= 17'd0;
            read_count_q  <= 17'd0;
            pixel_addr_q  <= 17'd0;
            pixel_data_q  <= '0;
            pixel_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
            empty_q       <= 1'b1;
            full_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            write_count_q <= write_count_d;
            read_count_q  <= read_count_d;
            pixel_addr_q  <= pixel_addr_d;
            pixel_data_q  <= pixel_data_d;
            pixel_valid_q <= pixel_valid_d;
            frame_done_q  <= frame_done_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
            empty_q       <= empty_d;
            full_q        <= full_d;
        end
    end

    // Pixel storage write port; left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[wr_addr_s] <= pixelDataIn;
        end
    end

    assign pixelDataOut = pixel_data_q;
    assign pixelValid   = pixel_valid_q;
    assign pixelAddr    = pixel_addr_q;
    assign level        = level_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign frameDone    = frame_done_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
endmodule

// File: tb/tb_ov7670_frame_fifo.sv
// Directed bench for ov7670_frame_fifo: default build plus a FRAME_PIXELS=8 build for frame-end behaviour.
module tb_ov7670_frame_fifo;
    logic        clk = 1'b0;
    logic        reset;
    logic        fs, np, pr;
    logic [15:0] pd;
    logic [15:0] dout;
    logic        valid, done, ovf, unf, emp, ful;
    logic [16:0] addr;
    logic [9:0]  lvl;

    logic        fs8, np8, pr8;
    logic [15:0] pd8;
    logic [15:0] dout8;
    logic        valid8, done8, ovf8, unf8, emp8, ful8;
    logic [16:0] addr8;
    logic [4:0]  lvl8;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    ov7670_frame_fifo dut (
        .clk(clk), .reset(reset), .frameStart(fs), .newPixel(np), .pixelDataIn(pd),
        .pixelReq(pr), .pixelDataOut(dout), .pixelValid(valid), .pixelAddr(addr),
        .level(lvl), .empty(emp), .full(ful), .frameDone(done), .overflow(ovf), .underflow(unf)
    );

    ov7670_frame_fifo #(.DATA_WIDTH(16), .DEPTH(16), .FRAME_PIXELS(8)) dut8 (
        .clk(clk), .reset(reset), .frameStart(fs8), .newPixel(np8), .pixelDataIn(pd8),
        .pixelReq(pr8), .pixelDataOut(dout8), .pixelValid(valid8), .pixelAddr(addr8),
        .level(lvl8), .empty(emp8), .full(ful8), .frameDone(done8), .overflow(ovf8), .underflow(unf8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        fs = 1'b0; np = 1'b0; pr = 1'b0; pd = 16'h0000;
        fs8 = 1'b0; np8 = 1'b0; pr8 = 1'b0; pd8 = 16'h0000;
        tick(); tick();
        chk("rst_level", 32'(lvl), 32'd0);
        chk("rst_empty", 32'(emp), 32'd1);
        chk("rst_full", 32'(ful), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_data", 32'(dout), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_flags", {29'd0, done, ovf, unf}, 32'd0);

        reset = 1'b1;
        np = 1'b1; pd = 16'h1111;
        tick();
        np = 1'b0;
        chk("idle_write_ignored", 32'(lvl), 32'd0);

        // Basic stream of five pixels, then five single-cycle pulls.
        fs = 1'b1; tick(); fs = 1'b0;
        chk("fs_level", 32'(lvl), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            np = 1'b1; pd = 16'(i); tick();
        end
        np = 1'b0;
        chk("five_level", 32'(lvl), 32'd5);
        for (int i = 0; i < 5; i++) begin
            pr = 1'b1; tick(); pr = 1'b0;
            chk("pop_valid", 32'(valid), 32'd1);
            chk("pop_data", 32'(dout), 32'(i + 1));
            chk("pop_addr", 32'(addr), 32'(i));
            chk("pop_level", 32'(lvl), 32'(4 - i));
            tick();
            chk("pop_valid_pulse", 32'(valid), 32'd0);
            chk("pop_data_hold", 32'(dout), 32'(i + 1));
        end
        chk("drained_empty", 32'(emp), 32'd1);
        chk("no_underflow_yet", 32'(unf), 32'd0);

        // Underflow then clear by frameStart.
        pr = 1'b1; tick(); pr = 1'b0;
        chk("unf_valid", 32'(valid), 32'd0);
        chk("unf_set", 32'(unf), 32'd1);
        fs = 1'b1; tick(); fs = 1'b0;
        chk("unf_cleared", 32'(unf), 32'd0);

        // Fill to DEPTH, overflow, then simultaneous read+write while full.
        for (int i = 0; i < 512; i++) begin
            np = 1'b1; pd = 16'(i); tick();
        end
        np = 1'b0;
        chk("fill_full", 32'(ful), 32'd1);
        chk("fill_level", 32'(lvl), 32'd512);
        chk("fill_no_ovf", 32'(ovf), 32'd0);
        np = 1'b1; pd = 16'hFFFF; tick(); np = 1'b0;
        chk("ovf_set", 32'(ovf), 32'd1);
        chk("ovf_level", 32'(lvl), 32'd512);
        np = 1'b1; pr = 1'b1; pd = 16'h7777; tick(); np = 1'b0; pr = 1'b0;
        chk("rw_full_level", 32'(lvl), 32'd512);
        chk("rw_full_full", 32'(ful), 32'd1);
        chk("rw_full_valid", 32'(valid), 32'd1);
        chk("rw_full_data", 32'(dout), 32'h0000);
        chk("rw_full_addr", 32'(addr), 32'd0);
        pr = 1'b1; tick(); pr = 1'b0;
        chk("after_drop_data", 32'(dout), 32'h0001);
        chk("after_drop_addr", 32'(addr), 32'd1);
        chk("after_drop_level", 32'(lvl), 32'd511);

        // Mid-frame flush with coincident write and read.
        fs = 1'b1; tick(); fs = 1'b0;
        for (int i = 0; i < 20; i++) begin
            np = 1'b1; pd = 16'(16'h0200 + i); tick();
        end
        np = 1'b0;
        chk("mid_level", 32'(lvl), 32'd20);
        fs = 1'b1; np = 1'b1; pr = 1'b1; pd = 16'hABCD; tick();
        fs = 1'b0; np = 1'b0; pr = 1'b0;
        chk("flush_level", 32'(lvl), 32'd1);
        chk("flush_pop_discarded", 32'(valid), 32'd0);
        chk("flush_flags", {30'd0, ovf, unf}, 32'd0);
        pr = 1'b1; tick(); pr = 1'b0;
        chk("flush_pop_valid", 32'(valid), 32'd1);
        chk("flush_pop_data", 32'(dout), 32'hABCD);
        chk("flush_pop_addr", 32'(addr), 32'd0);
        chk("flush_pop_level", 32'(lvl), 32'd0);

        // Short-frame build: ten writes, only eight stored, frameDone on the last pop.
        fs8 = 1'b1; tick(); fs8 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            np8 = 1'b1; pd8 = 16'(16'h0100 + i); tick();
        end
        np8 = 1'b0;
        chk("f8_level", 32'(lvl8), 32'd8);
        chk("f8_no_ovf", 32'(ovf8), 32'd0);
        pr8 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("f8_valid", 32'(valid8), 32'd1);
            chk("f8_addr", 32'(addr8), 32'(k));
            chk("f8_data", 32'(dout8), 32'(16'h0100 + k));
            chk("f8_done", 32'(done8), (k == 7) ? 32'd1 : 32'd0);
        end
        tick();
        pr8 = 1'b0;
        chk("f8_idle_valid", 32'(valid8), 32'd0);
        chk("f8_idle_unf", 32'(unf8), 32'd0);
        chk("f8_idle_done", 32'(done8), 32'd0);
        chk("f8_empty", 32'(emp8), 32'd1);

        // Asynchronous reset between clock edges.
        fs = 1'b1; tick(); fs = 1'b0;
        for (int i = 0; i < 3; i++) begin
            np = 1'b1; pd = 16'(16'h0AAA + i); tick();
        end
        np = 1'b0;
        pr = 1'b1; tick(); tick(); pr = 1'b0;
        chk("pre_rst_addr", 32'(addr), 32'd1);
        chk("pre_rst_data", 32'(dout), 32'h0AAB);
        np = 1'b1; pd = 16'h5555;
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        chk("arst_level", 32'(lvl), 32'd0);
        chk("arst_empty", 32'(emp), 32'd1);
        chk("arst_full", 32'(ful), 32'd0);
        chk("arst_data", 32'(dout), 32'd0);
        chk("arst_addr", 32'(addr), 32'd0);
        chk("arst_valid", 32'(valid), 32'd0);
        chk("arst_flags", {29'd0, done, ovf, unf}, 32'd0);
        #2;
        reset = 1'b1;
        tick(); tick();
        np = 1'b0;
        chk("post_rst_idle", 32'(lvl), 32'd0);
        chk("post_rst_empty", 32'(emp), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
